// File: rtl/c_mutex_pkg.sv
// ---------------------------------------------------------------------------
// c_mutex_pkg
// Shared definitions for the split/merge mutex blocks: channel count, select
// width, the transaction FSM state encoding and a select legality helper.
// ---------------------------------------------------------------------------
package c_mutex_pkg;

    localparam int NUM_CH = 9;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // A select value is legal when it names an existing channel.
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        return sel <= SEL_W'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/c_split_timer.sv
// ---------------------------------------------------------------------------
// c_split_timer
// Watchdog counter for the WAIT state of the split mutex.
//   clk     : clock
//   rst     : synchronous active-low reset (count -> 0)
//   clear   : zero the count (asserted the cycle before WAIT is entered)
//   enable  : count while high (high in WAIT)
//   limit   : number of enabled cycles after which expired asserts
//   expired : combinational, high in the enabled cycle that is the
//             limit-th one since the last clear
// ---------------------------------------------------------------------------
module c_split_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count starts at 0 in the first WAIT cycle, so the limit-th cycle of
    // WAIT is the one where the count equals limit-1.
    assign expired = enable && (count_q >= (limit - CNT_W'(1)));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/c_mutex_split9.sv
// ---------------------------------------------------------------------------
// c_mutex_split9
// Routes one upstream request/completion handshake to one of nine downstream
// channels, one transaction at a time.
//   clk     : clock, all state on the rising edge
//   rst     : synchronous active-low reset
//   i_drive : upstream request pulse
//   i_sel   : destination channel (0..8), sampled with i_drive
//   o_free  : upstream completion pulse
//   o_drive : per-channel downstream request pulses
//   i_free  : per-channel downstream completion pulses
//   o_busy  : high whenever the FSM is not IDLE
//   o_err   : sticky protocol-error flag, cleared only by reset
// Optional feature: define C_MUTEX_SPLIT9_TIMEOUT_EN to add a WAIT watchdog
// of TIMEOUT_CYCLES cycles that forces completion and flags an error.
// ---------------------------------------------------------------------------
module c_mutex_split9
    import c_mutex_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [SEL_W-1:0]  i_sel,
    output logic              o_free,
    output logic [NUM_CH-1:0] o_drive,
    input  logic [NUM_CH-1:0] i_free,
    output logic              o_busy,
    output logic              o_err
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                err_q, err_d;
    logic [NUM_CH-1:0]   drive_q, drive_d;
    logic                free_q, free_d;
    logic                busy_q, busy_d;

    logic [NUM_CH-1:0]   sel_onehot;
    logic                free_sel;
    logic                free_other;
    logic                timeout_hit;

    // Per-channel decode of the latched select, and the registered request
    // pulse computed from the next state so it lines up with ISSUE.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign sel_onehot[gi] = (sel_q == SEL_W'(gi));
        assign drive_d[gi]    = (state_d == ST_ISSUE) && (sel_d == SEL_W'(gi));
    end

    assign free_sel   = |(i_free & sel_onehot);
    assign free_other = |(i_free & ~sel_onehot);

`ifdef C_MUTEX_SPLIT9_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Cleared during ISSUE so the count is zero on the first WAIT cycle.
    c_split_timer #(
        .CNT_W (TMO_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ST_ISSUE),
        .enable  (state_q == ST_WAIT),
        .limit   (TMO_W'(TIMEOUT_CYCLES)),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_drive) begin
                    if (sel_legal(i_sel)) begin
                        sel_d   = i_sel;
                        state_d = ST_ISSUE;
                    end else begin
                        // Bad channel: complete upstream without any request.
                        state_d = ST_RELEASE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (free_sel) begin
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    state_d = ST_RELEASE;
                    err_d   = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Protocol violations: requests while busy, completions that do not
        // belong to the outstanding transaction.
        if (i_drive && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end
        if (state_q == ST_WAIT) begin
            if (free_other) begin
                err_d = 1'b1;
            end
        end else if (|i_free) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        free_d = (state_d == ST_RELEASE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            err_q   <= 1'b0;
            drive_q <= '0;
            free_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            drive_q <= drive_d;
            free_q  <= free_d;
            busy_q  <= busy_d;
        end
    end

    assign o_drive = drive_q;
    assign o_free  = free_q;
    assign o_busy  = busy_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_c_mutex_split9.sv
// ---------------------------------------------------------------------------
// tb_c_mutex_split9
// Self-checking bench for c_mutex_split9. Expected o_drive / o_free events are
// queued when stimulus is applied and matched as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_c_mutex_split9;

`ifdef C_MUTEX_SPLIT9_TIMEOUT_EN
    localparam int unsigned TB_TMO = 4;
`else
    localparam int unsigned TB_TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_drive = 1'b0;
    logic [3:0] i_sel = 4'd0;
    logic       o_free;
    logic [8:0] o_drive;
    logic [8:0] i_free = 9'd0;
    logic       o_busy;
    logic       o_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [8:0] drive;
        logic       free;
    } ev_t;

    typedef struct {
        logic [3:0]  sel;
        int unsigned gap;
        logic [8:0]  stray;
        logic        exp_err;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[8];

    c_mutex_split9 #(
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_drive (i_drive),
        .i_sel   (i_sel),
        .o_free  (o_free),
        .o_drive (o_drive),
        .i_free  (i_free),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Output monitor: every o_drive / o_free event must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        if ((o_drive != 9'd0) || o_free) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d actual drive=%h free=%b required none",
                         cyc, o_drive, o_free);
            end else begin
                e = sb.pop_front();
                if ((e.cyc != cyc) || (e.drive !== o_drive) || (e.free !== o_free)) begin
                    errors++;
                    $display("FAIL event cyc=%0d actual drive=%h free=%b required cyc=%0d drive=%h free=%b",
                             cyc, o_drive, o_free, e.cyc, e.drive, e.free);
                end else begin
                    $display("txn cyc=%0d drive=%h free=%b ok", cyc, o_drive, o_free);
                end
            end
        end else if ((sb.size() > 0) && (sb[0].cyc < cyc)) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d actual none required cyc=%0d drive=%h free=%b",
                     cyc, e.cyc, e.drive, e.free);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        i_drive = 1'b0;
        i_free  = 9'd0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Issue a request this cycle and queue the response it must produce.
    task automatic start(input logic [3:0] sel);
        ev_t e;
        i_drive = 1'b1;
        i_sel   = sel;
        e.cyc   = cyc + 1;
        if (sel <= 4'd8) begin
            e.drive = 9'd1 << sel;
            e.free  = 1'b0;
        end else begin
            e.drive = 9'd0;
            e.free  = 1'b1;
        end
        sb.push_back(e);
        tick();
        i_drive = 1'b0;
        i_sel   = 4'd0;
    endtask

    task automatic finish_ch(input logic [8:0] bits, input bit expect_done);
        ev_t e;
        i_free = bits;
        if (expect_done) begin
            e.cyc   = cyc + 1;
            e.drive = 9'd0;
            e.free  = 1'b1;
            sb.push_back(e);
        end
        tick();
        i_free = 9'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int bad;

        vecs[0] = '{4'd3,  3, 9'h000, 1'b0};
        vecs[1] = '{4'd0,  0, 9'h000, 1'b0};
        vecs[2] = '{4'd8,  5, 9'h000, 1'b0};
        vecs[3] = '{4'd5,  2, 9'h004, 1'b1};
        vecs[4] = '{4'd12, 0, 9'h000, 1'b1};
        vecs[5] = '{4'd9,  0, 9'h000, 1'b1};
        vecs[6] = '{4'd15, 0, 9'h000, 1'b1};
        vecs[7] = '{4'd7,  1, 9'h100, 1'b1};

        // Table-driven single transactions, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            @(negedge clk);
            check($sformatf("rst_out_v%0d", v), {o_drive, o_free, o_busy, o_err}, 32'd0);
            tick();
            start(vecs[v].sel);
            if (vecs[v].sel <= 4'd8) begin
                tick();
                repeat (vecs[v].gap) tick();
                finish_ch((9'd1 << vecs[v].sel) | vecs[v].stray, 1'b1);
            end
            tick();
            @(negedge clk);
            check($sformatf("err_v%0d", v), o_err, vecs[v].exp_err);
            check($sformatf("idle_v%0d", v), o_busy, 1'b0);
        end

        // Exact cycle walk: request at N on channel 3, completion at N+5.
        do_reset();
        tick();
        n = cyc;
        start(4'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("busy_walk_%0d", k), o_busy,
                  ((cyc >= n + 1) && (cyc <= n + 6)) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
            if (cyc == n + 5) begin
                ev_t e;
                i_free  = 9'h008;
                e.cyc   = cyc + 1;
                e.drive = 9'd0;
                e.free  = 1'b1;
                sb.push_back(e);
            end else begin
                i_free = 9'd0;
            end
        end
        i_free = 9'd0;
        check("walk_err", o_err, 1'b0);

        // Back-to-back: channel 0 then channel 8, new request two cycles after free.
        do_reset();
        tick();
        start(4'd0);
        tick();
        finish_ch(9'h001, 1'b1);
        tick();
        start(4'd8);
        tick();
        finish_ch(9'h100, 1'b1);
        tick();
        @(negedge clk);
        check("b2b_err", o_err, 1'b0);
        check("b2b_busy", o_busy, 1'b0);

        // Stray free on another channel and a request while busy, then normal completion.
        do_reset();
        tick();
        start(4'd5);
        tick();
        finish_ch(9'h004, 1'b0);
        i_drive = 1'b1;
        i_sel   = 4'd1;
        tick();
        i_drive = 1'b0;
        finish_ch(9'h020, 1'b1);
        tick();
        @(negedge clk);
        check("stray_err", o_err, 1'b1);
        check("stray_busy", o_busy, 1'b0);

        // Completion pulse while IDLE is a protocol error.
        do_reset();
        tick();
        finish_ch(9'h002, 1'b0);
        @(negedge clk);
        check("idle_free_err", o_err, 1'b1);
        check("idle_free_busy", o_busy, 1'b0);

        // Reset on the same edge as the channel's completion abandons the transaction.
        do_reset();
        tick();
        start(4'd4);
        tick();
        i_free = 9'h010;
        rst    = 1'b0;
        tick();
        i_free = 9'd0;
        rst    = 1'b1;
        @(negedge clk);
        check("rst_wait_out", {o_drive, o_free, o_busy, o_err}, 32'd0);
        repeat (5) tick();
        @(negedge clk);
        check("rst_wait_busy", o_busy, 1'b0);

        // Watchdog behaviour.
        do_reset();
        tick();
`ifdef C_MUTEX_SPLIT9_TIMEOUT_EN
        begin
            ev_t e;
            e.cyc   = cyc + 1 + 4 + 1;
            e.drive = 9'd0;
            e.free  = 1'b1;
            start(4'd2);
            sb.push_back(e);
        end
        repeat (8) tick();
        @(negedge clk);
        check("tmo_err", o_err, 1'b1);
        check("tmo_busy", o_busy, 1'b0);
`else
        start(4'd2);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (o_busy !== 1'b1) bad++;
        end
        check("no_tmo_busy_hold", bad, 0);
        check("no_tmo_err", o_err, 1'b0);
        do_reset();
`endif

        repeat (3) tick();
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
